pipeline_hazard_ctrl: RTL

Sequences the five-stage 64-bit RISC-V pipeline by driving the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards each cycle:
- load-use data hazards, by inserting a bubble;
- taken branches resolved in MEM, by flushing three younger instructions;
- data-memory wait states, by freezing the pipeline.

It also keeps saturating event counters and a sticky memory-timeout flag for debug. It sits beside the pipeline registers in the top-level core.

---
 rtl/pipeline_hazard_ctrl_if.sv | 53 +++++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Hazard-control bundle between the pipeline registers and
//                the hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if;
    // Pipeline status seen by the controller
    logic [4:0]  IFID_rs1;
    logic [4:0]  IFID_rs2;
    logic        IFID_uses_rs2;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_rd;
    logic        EXMEM_Branch_Taken;
    logic        mem_busy;

    // Register enables and flushes
    logic        PC_Write;
    logic        IFID_Write;
    logic        IFID_Flush;
    logic        IDEX_Write;
    logic        IDEX_Flush;
    logic        EXMEM_Write;
    logic        EXMEM_Flush;
    logic        MEMWB_Flush;

    // Debug observation
    logic [1:0]  state;
    logic [31:0] stall_count;
    logic [31:0] freeze_count;
    logic [31:0] flush_count;
    logic        mem_timeout;

    modport master (
        output IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_MemRead, IDEX_rd,
               EXMEM_Branch_Taken, mem_busy,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
               EXMEM_Write, EXMEM_Flush, MEMWB_Flush,
               state, stall_count, freeze_count, flush_count, mem_timeout
    );

    modport slave (
        input  IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_MemRead, IDEX_rd,
               EXMEM_Branch_Taken, mem_busy,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
               EXMEM_Write, EXMEM_Flush, MEMWB_Flush,
               state, stall_count, freeze_count, flush_count, mem_timeout
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Five-stage pipeline hazard controller: load-use bubble,
//                taken-branch flush, memory-wait freeze, debug counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  wire logic             clock,
    input  wire logic             reset,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_STALL  = 2'd1;
    localparam logic [1:0] c_FREEZE = 2'd2;
    localparam logic [1:0] c_FLUSH  = 2'd3;

    localparam logic [31:0]          c_CNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [TIMEOUT_W-1:0] c_BUSY_MAX = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] c_TMO_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    logic                 w_load_use;
    logic [1:0]           w_action;
    logic                 w_pc_write;
    logic                 w_ifid_write;
    logic                 w_ifid_flush;
    logic                 w_idex_write;
    logic                 w_idex_flush;
    logic                 w_exmem_write;
    logic                 w_exmem_flush;
    logic                 w_memwb_flush;

    logic [1:0]           r_state;
    logic [31:0]          r_stall_count;
    logic [31:0]          r_freeze_count;
    logic [31:0]          r_flush_count;
    logic [TIMEOUT_W-1:0] r_busy_cnt;
    logic                 r_mem_timeout;

    always_comb begin
        w_load_use = hz.IDEX_MemRead && (hz.IDEX_rd != 5'd0) &&
                     ((hz.IDEX_rd == hz.IFID_rs1) ||
                      (hz.IFID_uses_rs2 && (hz.IDEX_rd == hz.IFID_rs2)));

        // Reset forces RUN so the pipeline sees plain defaults while held.
        if (reset)
            w_action = c_RUN;
        else if (hz.mem_busy)
            w_action = c_FREEZE;
        else if (hz.EXMEM_Branch_Taken)
            w_action = c_FLUSH;
        else if (w_load_use)
            w_action = c_STALL;
        else
            w_action = c_RUN;
    end

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_write  = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_write = 1'b1;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;
        case (w_action)
            c_FREEZE: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_idex_write  = 1'b0;
                w_exmem_write = 1'b0;
                w_memwb_flush = 1'b1;
            end
            c_FLUSH: begin
                w_ifid_flush  = 1'b1;
                w_idex_flush  = 1'b1;
                w_exmem_flush = 1'b1;
            end
            c_STALL: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_idex_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    assign hz.PC_Write    = w_pc_write;
    assign hz.IFID_Write  = w_ifid_write;
    assign hz.IFID_Flush  = w_ifid_flush;
    assign hz.IDEX_Write  = w_idex_write;
    assign hz.IDEX_Flush  = w_idex_flush;
    assign hz.EXMEM_Write = w_exmem_write;
    assign hz.EXMEM_Flush = w_exmem_flush;
    assign hz.MEMWB_Flush = w_memwb_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_RUN;
            r_stall_count  <= '0;
            r_freeze_count <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_action;
            if (w_action == c_STALL && r_stall_count != c_CNT_MAX)
                r_stall_count <= r_stall_count + 32'd1;
            if (w_action == c_FREEZE && r_freeze_count != c_CNT_MAX)
                r_freeze_count <= r_freeze_count + 32'd1;
            if (w_action == c_FLUSH && r_flush_count != c_CNT_MAX)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    // The timeout flag is sticky; only reset releases it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (hz.mem_busy) begin
            if (r_busy_cnt != c_BUSY_MAX)
                r_busy_cnt <= r_busy_cnt + 1'b1;
            if (r_busy_cnt == c_TMO_LAST)
                r_mem_timeout <= 1'b1;
        end else begin
            r_busy_cnt <= '0;
        end
    end

    assign hz.state        = r_state;
    assign hz.stall_count  = r_stall_count;
    assign hz.freeze_count = r_freeze_count;
    assign hz.flush_count  = r_flush_count;
    assign hz.mem_timeout  = r_mem_timeout;

endmodule

`default_nettype wire
